// File: rtl/test_status_port.sv
// Test-status / signature device: latches the TOHOST verdict, buffers SIG words
// in a show-ahead FIFO, and raises sim_done once drained. Optional watchdog: TEST_STATUS_TIMEOUT_EN.
module test_status_port #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        sig_valid,
    input  logic        sig_ready,
    output logic [31:0] sig_data,
    output logic        test_end,
    output logic        test_pass,
    output logic [30:0] test_num,
    output logic        sig_overflow,
    output logic        timeout,
    output logic        sim_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [29:0] TOHOST_W = BASE_ADDR[31:2];
    localparam logic [29:0] SIG_W    = TOHOST_W + 30'd1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count, count_next;
    logic        empty, full, pop, push_req, push, verdict, wdog_fire;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^wr_addr[1:0];

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = ~empty & sig_ready;
    assign push_req   = wr_en & (wr_addr[31:2] == SIG_W) & (state != DONE);
    // a full FIFO still takes the word when the head leaves on the same edge
    assign push       = push_req & (~full | pop);
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign verdict    = wr_en & (wr_addr[31:2] == TOHOST_W) & wr_data[0] & (state == RUN);

    assign sig_valid = ~empty;
    assign sig_data  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
    assign sim_done  = (state == DONE);

`ifdef TEST_STATUS_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;

    assign wdog_fire = (state == RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES));
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state == RUN) begin
            wd_cnt <= (verdict | push) ? 32'd0 : wd_cnt + 32'd1;
            // a TOHOST write landing with the timeout takes precedence
            if (wdog_fire && !verdict)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (verdict || wdog_fire) state_next = DRAIN;
            DRAIN:   if (count_next == '0)     state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            test_end  <= 1'b0;
            test_pass <= 1'b0;
            test_num  <= '0;
        end else if (state == RUN) begin
            if (verdict) begin
                test_end  <= 1'b1;
                test_pass <= (wr_data == 32'h1);
                test_num  <= (wr_data == 32'h1) ? 31'd0 : wr_data[31:1];
            end else if (wdog_fire) begin
                test_end  <= 1'b1;
                test_pass <= 1'b0;
                test_num  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sig_overflow <= 1'b0;
        end else begin
            if (push)            wr_ptr       <= wr_ptr + 1'b1;
            if (pop)             rd_ptr       <= rd_ptr + 1'b1;
            if (push_req & ~push) sig_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_test_status_port.sv
// Self-checking bench for test_status_port: directed scenarios plus a randomized
// run against a queue-based reference model of the register window and FIFO.
module tb_test_status_port;
    localparam bit [31:0] BASE  = 32'h8000_1000;
    localparam int        DEPTH = 16;
    localparam bit [31:0] TOH   = BASE;
    localparam bit [31:0] SIG   = BASE + 32'd4;

    logic        clk = 1'b0, rst = 1'b0, wr_en = 1'b0, sig_ready = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic        sig_valid, test_end, test_pass, sig_overflow, timeout, sim_done;
    logic [31:0] sig_data;
    logic [30:0] test_num;

    int errors = 0, checks = 0;

    // reference model: state is "not ended", "draining", "done"
    int unsigned mq[$];
    bit          m_end, m_pass, m_ovf, m_drain, m_done;
    bit [30:0]   m_num;

    test_status_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data),
        .test_end(test_end), .test_pass(test_pass), .test_num(test_num),
        .sig_overflow(sig_overflow), .timeout(timeout), .sim_done(sim_done)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_end = 0; m_pass = 0; m_ovf = 0; m_drain = 0; m_done = 0; m_num = '0;
    endtask

    task automatic tick(input bit we, input bit [31:0] a, input bit [31:0] d, input bit rdy);
        bit pop, is_t, is_s, was_drain, was_full;
        wr_en = we; wr_addr = a; wr_data = d; sig_ready = rdy;
        was_drain = m_drain && !m_done;
        was_full  = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() > 0);
        is_t = we && (a[31:2] == TOH[31:2]);
        is_s = we && (a[31:2] == SIG[31:2]);
        if (pop) void'(mq.pop_front());
        if (is_s && !m_done) begin
            if (!was_full || pop) mq.push_back(d);
            else m_ovf = 1;
        end
        if (was_drain) begin
            if (mq.size() == 0) m_done = 1;
        end else if (!m_drain && is_t && d[0]) begin
            m_drain = 1; m_end = 1; m_pass = (d == 32'h1);
            m_num = m_pass ? 31'd0 : d[31:1];
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_en = 0; sig_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({sig_valid, test_end, test_pass, sig_overflow, timeout, sim_done} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                {sig_valid, test_end, test_pass, sig_overflow, timeout, sim_done}); end
        checks++; if (sig_data !== 32'h0 || test_num !== 31'h0) begin
            errors++; $display("FAIL reset_data: got data=%h num=%h expected 0/0", sig_data, test_num); end
    endtask

    task automatic test_pass_verdict();
        do_reset();
        tick(1, TOH, 32'h1, 1);
        checks++; if ({test_end, test_pass} !== 2'b11) begin
            errors++; $display("FAIL pass_verdict: got end/pass=%b expected 11", {test_end, test_pass}); end
        checks++; if (test_num !== 31'd0 || sim_done !== 1'b0) begin
            errors++; $display("FAIL pass_num: got num=%0d done=%b expected 0/0", test_num, sim_done); end
        tick(0, 32'h0, 32'h0, 1);
        checks++; if (sim_done !== 1'b1) begin
            errors++; $display("FAIL pass_sim_done: got %b expected 1", sim_done); end
    endtask

    task automatic test_fail_verdict();
        do_reset();
        tick(1, TOH, 32'h4, 1);
        checks++; if (test_end !== 1'b0) begin
            errors++; $display("FAIL even_tohost_ignored: got end=%b expected 0", test_end); end
        tick(1, TOH + 32'd2, 32'h0000_000B, 1);
        checks++; if ({test_end, test_pass} !== 2'b10 || test_num !== 31'd5) begin
            errors++; $display("FAIL fail_verdict: got end/pass=%b num=%0d expected 10/5", {test_end, test_pass}, test_num); end
        tick(1, TOH, 32'h1, 1);
        tick(0, 32'h0, 32'h0, 1);
        checks++; if (test_pass !== 1'b0 || test_num !== 31'd5 || sim_done !== 1'b1) begin
            errors++; $display("FAIL first_verdict_wins: got pass=%b num=%0d done=%b expected 0/5/1", test_pass, test_num, sim_done); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, SIG, 32'hA0 + i, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 32'h0, 32'h0, 0);
            checks++; if (sig_valid !== 1'b1 || sig_data !== 32'hA0) begin
                errors++; $display("FAIL stall_hold: got valid=%b data=%h expected 1/a0", sig_valid, sig_data); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sig_data !== 32'hA0 + i) begin
                errors++; $display("FAIL drain_order[%0d]: got %h expected %h", i, sig_data, 32'hA0 + i); end
            if (i == 0) tick(1, TOH, 32'h1, 1);
            else        tick(0, 32'h0, 32'h0, 1);
            checks++; if (sim_done !== (i == 3)) begin
                errors++; $display("FAIL drain_done[%0d]: got %b expected %b", i, sim_done, i == 3); end
        end
    endtask

    task automatic test_overflow();
        int pops;
        logic [31:0] last;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) tick(1, SIG, 32'h100 + i, 0);
        checks++; if (sig_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_flag: got %b expected 1", sig_overflow); end
        pops = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (sig_valid) begin
                checks++; if (sig_data !== 32'h100 + pops) begin
                    errors++; $display("FAIL overflow_order[%0d]: got %h expected %h", pops, sig_data, 32'h100 + pops); end
                pops++;
            end
            tick(0, 32'h0, 32'h0, 1);
        end
        checks++; if (pops !== DEPTH) begin
            errors++; $display("FAIL overflow_count: got %0d expected %0d", pops, DEPTH); end

        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, SIG, 32'h200 + i, 0);
        tick(1, SIG, 32'h55, 1);
        checks++; if (sig_overflow !== 1'b0 || sig_data !== 32'h201) begin
            errors++; $display("FAIL full_push_pop: got ovf=%b head=%h expected 0/201", sig_overflow, sig_data); end
        last = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (sig_valid) last = sig_data;
            tick(0, 32'h0, 32'h0, 1);
        end
        checks++; if (last !== 32'h55) begin
            errors++; $display("FAIL full_push_pop_tail: got %h expected 55", last); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, SIG, 32'h300 + i, 0);
        tick(1, TOH, 32'h1, 0);
        tick(0, 32'h0, 32'h0, 0);
        checks++; if (test_end !== 1'b1 || sim_done !== 1'b0 || sig_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_drain: got end=%b done=%b valid=%b expected 1/0/1", test_end, sim_done, sig_valid); end
        do_reset();
        checks++; if ({sig_valid, test_end, test_pass, sig_overflow, sim_done} !== 5'b0 || sig_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid_drain: got flags=%b data=%h expected 00000/0",
                {sig_valid, test_end, test_pass, sig_overflow, sim_done}, sig_data); end
    endtask

    task automatic test_random();
        int r;
        bit [31:0] a, d;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (m_done && r < 8) begin
                do_reset();
                continue;
            end
            d = $urandom;
            if      (r < 45) a = SIG;
            else if (r < 47) begin a = TOH; d[0] = 1'b1; end
            else if (r < 52) begin a = TOH; d[0] = 1'b0; end
            else if (r < 60) a = BASE + 32'd8 + 32'(4 * $urandom_range(0, 8));
            else             a = 32'h0;
            a[1:0] = 2'($urandom_range(0, 3));
            tick(r < 60, a, d, 1'($urandom_range(0, 2) != 0 ? 1 : 0));
            checks++; if (sig_valid !== (mq.size() > 0) || sig_data !== (mq.size() > 0 ? mq[0] : 32'h0)) begin
                errors++; $display("FAIL rand_fifo@%0d: got valid=%b data=%h expected %b/%h", n, sig_valid, sig_data,
                    mq.size() > 0, mq.size() > 0 ? mq[0] : 32'h0); end
            checks++; if (test_end !== m_end || test_pass !== m_pass || test_num !== m_num
                          || sig_overflow !== m_ovf || sim_done !== m_done) begin
                errors++; $display("FAIL rand_status@%0d: got end=%b pass=%b num=%h ovf=%b done=%b expected %b/%b/%h/%b/%b",
                    n, test_end, test_pass, test_num, sig_overflow, sim_done, m_end, m_pass, m_num, m_ovf, m_done); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
`ifdef TEST_STATUS_TIMEOUT_EN
        for (int i = 0; i < 300; i++) tick((i % 50) == 49, SIG, 32'(i), 1);
        checks++; if (test_end !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL watchdog_kept_alive: got end=%b timeout=%b expected 0/0", test_end, timeout); end
        do_reset();
        for (int i = 0; i < 95; i++) tick(0, 32'h0, 32'h0, 1);
        checks++; if (test_end !== 1'b0) begin
            errors++; $display("FAIL watchdog_early: got end=%b expected 0", test_end); end
        for (int i = 0; i < 15; i++) tick(0, 32'h0, 32'h0, 1);
        checks++; if ({test_end, timeout, test_pass} !== 3'b110 || test_num !== 31'd0 || sim_done !== 1'b1) begin
            errors++; $display("FAIL watchdog_fire: got end/to/pass=%b num=%0d done=%b expected 110/0/1",
                {test_end, timeout, test_pass}, test_num, sim_done); end
`else
        for (int i = 0; i < 300; i++) tick(0, 32'h0, 32'h0, 1);
        checks++; if (test_end !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL no_watchdog: got end=%b timeout=%b expected 0/0", test_end, timeout); end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_pass_verdict();
        test_fail_verdict();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
